ecc_sram_scrub_ctrl: RTL and testbench

//  Controller in front of one single-port 72-bit SRAM holding SECDED(72,64) words.

---
 rtl/ecc_scrub_pkg.sv | 29 ++
 rtl/prim_secded_72_64_dec.sv | 31 +++
 rtl/prim_secded_72_64_enc.sv | 23 ++
 rtl/ecc_sram_scrub_ctrl.sv | 143 ++++++++++++++
 tb/tb_ecc_sram_scrub_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_scrub_pkg.sv
// Shared types and constants for the SECDED SRAM scrub controller.
// Holds the scrub FSM states, code widths and the data-bit syndrome columns.
// Columns are the 64 non-power-of-two values in 3..71 (extended Hamming code).
package ecc_scrub_pkg;

  localparam int DataWidth = 64;
  localparam int CodeWidth = 72;
  localparam logic [1:0] ErrCorr = 2'b01;

  typedef enum logic [1:0] {IDLE, S_CHK, S_WB} scrub_state_e;

  // Syndrome column of every data bit; check bit j covers data bits whose column has bit j set.
  function automatic logic [63:0][6:0] secded_cols();
    logic [63:0][6:0] cols;
    int n;
    cols = '0;
    n = 0;
    for (int v = 3; v < CodeWidth; v++) begin
      if ((v & (v - 1)) != 0) begin
        cols[n[5:0]] = 7'(v);
        n++;
      end
    end
    return cols;
  endfunction

  localparam logic [63:0][6:0] SecdedCols = secded_cols();

endpackage

// File: rtl/prim_secded_72_64_dec.sv
// SECDED(72,64) decoder: corrects any single-bit error, flags double errors.
// Latency: combinational.
// Backpressure: none.
module prim_secded_72_64_dec
  import ecc_scrub_pkg::*;
(
  input  logic [CodeWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic [1:0]           err_o
);

  logic [6:0] syn;
  logic       par;

  // Syndrome plus overall parity; odd parity with an in-range syndrome is a single error.
  always_comb begin
    syn = data_i[70:64];
    for (int i = 0; i < DataWidth; i++) begin
      if (data_i[i]) syn = syn ^ SecdedCols[i];
    end
    par    = ^data_i;
    data_o = data_i[DataWidth-1:0];
    for (int i = 0; i < DataWidth; i++) begin
      if (par && (syn == SecdedCols[i])) data_o[i] = ~data_i[i];
    end
    if (!par && (syn == 7'd0))      err_o = 2'b00;
    else if (par && (syn < 7'd72))  err_o = ErrCorr;
    else                            err_o = 2'b10;
  end

endmodule

// File: rtl/prim_secded_72_64_enc.sv
// SECDED(72,64) encoder: code = {overall parity, 7 Hamming checks, data}.
// Latency: combinational.
// Backpressure: none.
module prim_secded_72_64_enc
  import ecc_scrub_pkg::*;
(
  input  logic [DataWidth-1:0] data_i,
  output logic [CodeWidth-1:0] data_o
);

  logic [6:0] chk;

  // Hamming check bits: XOR of the columns of all set data bits.
  always_comb begin
    chk = '0;
    for (int i = 0; i < DataWidth; i++) begin
      if (data_i[i]) chk = chk ^ SecdedCols[i];
    end
  end

  assign data_o = {^{chk, data_i}, chk, data_i};

endmodule

// File: rtl/ecc_sram_scrub_ctrl.sv
// SECDED SRAM controller with background scrubber sharing one SRAM port.
// Latency: requester read data 1 cycle after grant; scrub takes 2 (clean/uncorr) or 3 (fix) cycles.
// Backpressure: requester has strict priority in IDLE; gnt_o is 0 while a scrub check/writeback runs.
module ecc_sram_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int NumWords      = 256,
  parameter int AddrWidth     = $clog2(NumWords),
  parameter int ScrubInterval = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scrub_en_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [1:0]           rerr_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [CodeWidth-1:0] sram_wdata_o,
  input  logic [CodeWidth-1:0] sram_rdata_i,
  output logic                 scrub_fix_o,
  output logic                 scrub_uncorr_o,
  output logic [31:0]          corr_cnt_o,
  output logic [31:0]          uncorr_cnt_o
);

  localparam int CntWidth = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;

  scrub_state_e         state_q, state_d;
  logic [AddrWidth-1:0] scrub_addr_q, scrub_addr_d, scrub_addr_nxt;
  logic [CntWidth-1:0]  ival_q;
  logic                 pend_q, pend_d;
  logic                 rvalid_q;
  logic [DataWidth-1:0] fix_data_q;
  logic [31:0]          corr_cnt_q, uncorr_cnt_q;
  logic [DataWidth-1:0] dec_data, enc_in;
  logic [1:0]           dec_err;
  logic [CodeWidth-1:0] enc_out;
  logic                 wrap;

  prim_secded_72_64_enc u_enc (.data_i(enc_in), .data_o(enc_out));
  prim_secded_72_64_dec u_dec (.data_i(sram_rdata_i), .data_o(dec_data), .err_o(dec_err));

  assign wrap           = scrub_en_i && (ival_q == CntWidth'(ScrubInterval - 1));
  assign scrub_addr_nxt = (scrub_addr_q == AddrWidth'(NumWords - 1)) ? '0
                        : scrub_addr_q + AddrWidth'(1);

  // Port arbitration, scrub sequencing and pending-trigger bookkeeping.
  always_comb begin
    state_d        = state_q;
    scrub_addr_d   = scrub_addr_q;
    pend_d         = pend_q;
    gnt_o          = 1'b0;
    sram_req_o     = 1'b0;
    sram_we_o      = 1'b0;
    sram_addr_o    = '0;
    enc_in         = wdata_i;
    scrub_fix_o    = 1'b0;
    scrub_uncorr_o = 1'b0;
    // A trigger is only latched while idle; one arriving mid-scrub is absorbed.
    if (wrap && (state_q == IDLE)) pend_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          gnt_o       = 1'b1;
          sram_req_o  = 1'b1;
          sram_we_o   = we_i;
          sram_addr_o = addr_i;
        end else if (pend_q) begin
          sram_req_o  = 1'b1;
          sram_addr_o = scrub_addr_q;
          pend_d      = 1'b0;
          state_d     = S_CHK;
        end
      end
      S_CHK: begin
        if (dec_err == ErrCorr) begin
          state_d = S_WB;
        end else begin
          scrub_uncorr_o = dec_err[1];
          scrub_addr_d   = scrub_addr_nxt;
          state_d        = IDLE;
        end
      end
      S_WB: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = scrub_addr_q;
        enc_in       = fix_data_q;
        scrub_fix_o  = 1'b1;
        scrub_addr_d = scrub_addr_nxt;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset suppresses every strobe in its own cycle, so an interrupted writeback never lands.
    if (rst) begin
      gnt_o          = 1'b0;
      sram_req_o     = 1'b0;
      sram_we_o      = 1'b0;
      sram_addr_o    = '0;
      scrub_fix_o    = 1'b0;
      scrub_uncorr_o = 1'b0;
    end
  end

  assign sram_wdata_o = (sram_req_o && sram_we_o) ? enc_out : '0;
  assign rvalid_o     = rvalid_q && !rst;
  assign rdata_o      = rvalid_o ? dec_data : '0;
  assign rerr_o       = rvalid_o ? dec_err : 2'b00;
  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;

  // State, interval counter, read-valid tracking and saturating error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      scrub_addr_q <= '0;
      ival_q       <= '0;
      pend_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      fix_data_q   <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
      pend_q       <= pend_d;
      ival_q       <= !scrub_en_i ? '0 : (wrap ? '0 : ival_q + CntWidth'(1));
      rvalid_q     <= gnt_o && !we_i;
      if (state_q == S_CHK) fix_data_q <= dec_data;
      if (scrub_fix_o && (corr_cnt_q != '1)) corr_cnt_q <= corr_cnt_q + 32'd1;
      if (scrub_uncorr_o && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_ecc_sram_scrub_ctrl.sv
// Bench for ecc_sram_scrub_ctrl: 1-cycle SRAM model with bit-flip injection,
// a transaction-level expectation model (golden data, flip masks, queued scrub steps)
// and directed scenarios followed by a randomized phase.
module tb_ecc_sram_scrub_ctrl;

  localparam int NW = 8;
  localparam int SI = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1, scrub_en_i = 1'b0, req_i = 1'b0, we_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [63:0]   wdata_i = '0;
  logic          gnt_o, rvalid_o, sram_req_o, sram_we_o, scrub_fix_o, scrub_uncorr_o;
  logic [63:0]   rdata_o;
  logic [1:0]    rerr_o;
  logic [AW-1:0] sram_addr_o;
  logic [71:0]   sram_wdata_o, sram_rdata_i, rd_next = '0;
  logic [31:0]   corr_cnt_o, uncorr_cnt_o;

  always #5 clk = ~clk;

  ecc_sram_scrub_ctrl #(.NumWords(NW), .AddrWidth(AW), .ScrubInterval(SI)) dut (
    .clk(clk), .rst(rst), .scrub_en_i(scrub_en_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .rerr_o(rerr_o), .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .scrub_fix_o(scrub_fix_o), .scrub_uncorr_o(scrub_uncorr_o),
    .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o));

  // SRAM read register: data appears one cycle after the read strobe.
  always @(posedge clk) sram_rdata_i <= rd_next;

  typedef struct {
    logic acc; logic we; logic [AW-1:0] addr; logic [71:0] wdat; logic fix; logic unc;
  } exp_t;

  logic [71:0] mem [NW], clean [NW], fmask [NW];
  logic [63:0] gold [NW];
  int          wr_cnt [NW];
  exp_t        q [$];
  int          m_cnt, m_saddr, m_rflips, scrub_starts, prev_scrub;
  bit          m_pend, m_rdp, wrap_seen;
  logic [63:0] m_rgold;
  logic [31:0] m_corr, m_unc;
  logic        s_rst, s_en, s_req, s_we;
  logic [AW-1:0] s_addr;
  logic [63:0] s_wdata;
  logic        smp_gnt, smp_rv, smp_sreq, smp_swe, smp_fix, smp_unc;
  logic [63:0] smp_rdata;
  logic [1:0]  smp_rerr;
  int          checks = 0, errors = 0;

  task automatic chk(input string n, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", n, act, exp);
    end
  endtask

  task automatic inject(input int a, input logic [71:0] m);
    mem[a]   = mem[a] ^ m;
    fmask[a] = fmask[a] ^ m;
  endtask

  // Per-cycle comparison against the model, then SRAM and model update.
  task automatic evaluate();
    exp_t it;
    bit   busy, start;
    logic e_gnt, e_rv;
    int   f;
    it = '{acc: 0, we: 0, addr: '0, wdat: '0, fix: 0, unc: 0};
    e_gnt = 0; e_rv = 0; start = 0;
    busy = (q.size() > 0);
    if (!rst) begin
      e_rv = m_rdp;
      if (busy) it = q.pop_front();
      else if (req_i) begin
        e_gnt = 1; it.acc = 1; it.we = we_i; it.addr = addr_i;
      end else if (m_pend) begin
        start = 1; it.acc = 1; it.addr = AW'(m_saddr);
      end
    end
    chk("gnt", gnt_o, e_gnt);
    chk("sram_req", sram_req_o, it.acc);
    chk("sram_we", sram_we_o, it.we);
    chk("sram_addr", sram_addr_o, it.addr);
    if (!it.acc || (busy && it.we)) chk("sram_wdata", sram_wdata_o, it.wdat);
    chk("rvalid", rvalid_o, e_rv);
    if (e_rv && m_rflips < 2) begin
      chk("rdata", rdata_o, m_rgold);
      chk("rerr", rerr_o, (m_rflips == 1) ? 2'b01 : 2'b00);
    end else if (e_rv) chk("rerr_unc", rerr_o[1], 1'b1);
    else begin
      chk("rdata_idle", rdata_o, 0);
      chk("rerr_idle", rerr_o, 0);
    end
    chk("scrub_fix", scrub_fix_o, it.fix);
    chk("scrub_uncorr", scrub_uncorr_o, it.unc);
    if (!rst) begin
      chk("corr_cnt", corr_cnt_o, m_corr);
      chk("uncorr_cnt", uncorr_cnt_o, m_unc);
    end
    smp_gnt = gnt_o; smp_rv = rvalid_o; smp_rdata = rdata_o; smp_rerr = rerr_o;
    smp_sreq = sram_req_o; smp_swe = sram_we_o; smp_fix = scrub_fix_o; smp_unc = scrub_uncorr_o;
    // SRAM follows whatever the DUT actually drives.
    if (sram_req_o && sram_we_o) begin
      mem[sram_addr_o] = sram_wdata_o;
      fmask[sram_addr_o] = '0;
      wr_cnt[sram_addr_o]++;
    end else if (sram_req_o) rd_next = mem[sram_addr_o];
    if (rst) begin
      q.delete();
      m_cnt = 0; m_pend = 0; m_saddr = 0; m_corr = 0; m_unc = 0; m_rdp = 0;
      prev_scrub = -1;
    end else begin
      if (start) begin
        if (prev_scrub == NW - 1 && m_saddr == 0) wrap_seen = 1;
        prev_scrub = m_saddr;
        f = $countones(fmask[m_saddr]);
        q.push_back('{acc: 0, we: 0, addr: '0, wdat: '0, fix: 0, unc: (f >= 2)});
        if (f == 1)
          q.push_back('{acc: 1, we: 1, addr: AW'(m_saddr), wdat: clean[m_saddr], fix: 1, unc: 0});
        m_saddr = (m_saddr + 1) % NW;
        scrub_starts++;
      end
      m_rdp = e_gnt && !we_i;
      if (e_gnt && we_i) begin
        gold[addr_i] = wdata_i;
        clean[addr_i] = sram_wdata_o;
      end else if (e_gnt) begin
        m_rgold = gold[addr_i];
        m_rflips = $countones(fmask[addr_i]);
      end
      if (it.fix && m_corr != 32'hFFFF_FFFF) m_corr++;
      if (it.unc && m_unc != 32'hFFFF_FFFF) m_unc++;
      if (start) m_pend = 0;
      else if (scrub_en_i && m_cnt == SI - 1 && !busy) m_pend = 1;
      m_cnt = scrub_en_i ? (m_cnt + 1) % SI : 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = s_rst; scrub_en_i = s_en; req_i = s_req; we_i = s_we; addr_i = s_addr; wdata_i = s_wdata;
    @(negedge clk);
    evaluate();
  endtask

  task automatic do_write(input int a, input logic [63:0] d);
    s_req = 1; s_we = 1; s_addr = AW'(a); s_wdata = d;
    step();
    s_req = 0; s_we = 0;
  endtask

  task automatic do_read(input int a);
    s_req = 1; s_we = 0; s_addr = AW'(a);
    step();
    s_req = 0;
    step();
  endtask

  task automatic drain();
    int n;
    s_req = 0; s_en = 0; n = 0;
    while ((q.size() > 0 || m_pend) && n < 50) begin
      step();
      n++;
    end
    chk("drain_done", (q.size() == 0 && !m_pend), 1);
  endtask

  initial begin
    bit   seen, hit;
    int   w0, a, b1, b2;
    logic [71:0] m;
    for (int i = 0; i < NW; i++) begin
      mem[i] = '0; clean[i] = '0; fmask[i] = '0; gold[i] = '0; wr_cnt[i] = 0;
    end
    m_cnt = 0; m_saddr = 0; m_rflips = 0; scrub_starts = 0; prev_scrub = -1;
    m_pend = 0; m_rdp = 0; wrap_seen = 0; m_rgold = '0; m_corr = '0; m_unc = '0;
    s_rst = 1; s_en = 0; s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    step(); step();
    s_rst = 0;
    step();
    chk("reset_gnt", smp_gnt, 0);
    chk("reset_corr_cnt", corr_cnt_o, 0);
    chk("reset_uncorr_cnt", uncorr_cnt_o, 0);
    for (int i = 0; i < NW; i++) do_write(i, {$urandom, $urandom});

    // Plain write/read round trip.
    do_write(5, 64'hDEAD_BEEF_0123_4567);
    do_read(5);
    chk("t1_rvalid", smp_rv, 1);
    chk("t1_rdata", smp_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("t1_rerr", smp_rerr, 2'b00);

    // Single flip seen by the requester is corrected but never written back.
    w0 = wr_cnt[5];
    inject(5, 72'd1 << 17);
    do_read(5);
    chk("t2_rdata", smp_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("t2_rerr", smp_rerr, 2'b01);
    chk("t2_no_write", wr_cnt[5] - w0, 0);

    // Scrubber fixes a single flip at address 2.
    w0 = wr_cnt[2];
    inject(2, 72'd1 << 3);
    s_en = 1; seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      if (smp_fix) seen = 1;
    end
    chk("t3_fix_seen", seen, 1);
    step();
    chk("t3_corr_cnt", corr_cnt_o, 32'd1);
    chk("t3_wb_count", wr_cnt[2] - w0, 1);
    chk("t3_restored", mem[2] ^ clean[2], 0);

    // Double flip at address 6 is reported, not written; address wraps after 7.
    w0 = wr_cnt[6];
    inject(6, (72'd1 << 0) | (72'd1 << 40));
    wrap_seen = 0; seen = 0;
    for (int c = 0; c < 400 && !(seen && wrap_seen); c++) begin
      step();
      if (smp_unc) seen = 1;
    end
    chk("t4_unc_seen", seen, 1);
    chk("t4_wrap_seen", wrap_seen, 1);
    chk("t4_uncorr_cnt", uncorr_cnt_o, 32'd1);
    chk("t4_no_write", wr_cnt[6] - w0, 0);
    drain();
    do_write(6, 64'h0F0F_0000_FFFF_1234);

    // Requester held across triggers starves the scrubber.
    w0 = scrub_starts; seen = 1;
    s_en = 1; s_req = 1; s_we = 0;
    for (int c = 0; c < 3 * SI + 2; c++) begin
      s_addr = AW'($urandom_range(0, NW - 1));
      step();
      if (!smp_gnt) seen = 0;
    end
    chk("t5_gnt_always", seen, 1);
    chk("t5_no_scrub", scrub_starts - w0, 0);
    s_req = 0;
    step();
    chk("t5_scrub_rd", {smp_sreq, smp_swe, smp_gnt}, 3'b100);
    s_req = 1;
    step();
    chk("t5_chk_blocks", smp_gnt, 0);
    drain();

    // Reset landing on a writeback cycle suppresses the write.
    w0 = wr_cnt[3];
    inject(3, 72'd1 << 50);
    s_en = 1; hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (q.size() > 0 && q[0].we) begin
        s_rst = 1; hit = 1;
      end
      step();
    end
    chk("t6_rst_in_wb", hit, 1);
    chk("t6_no_sram_req", smp_sreq, 0);
    s_rst = 0; s_en = 0;
    step();
    chk("t6_corr_cnt", corr_cnt_o, 0);
    chk("t6_uncorr_cnt", uncorr_cnt_o, 0);
    chk("t6_word_untouched", mem[3] ^ clean[3], 72'd1 << 50);
    chk("t6_wr_cnt", wr_cnt[3] - w0, 0);

    // Randomized traffic, triggers, injections and occasional resets.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) s_en = ~s_en;
      s_req = $urandom_range(0, 1) == 1;
      s_we = $urandom_range(0, 2) == 0;
      s_addr = AW'($urandom_range(0, NW - 1));
      s_wdata = {$urandom, $urandom};
      s_rst = $urandom_range(0, 399) == 0;
      if ($urandom_range(0, 19) == 0) begin
        a = $urandom_range(0, NW - 1);
        b1 = $urandom_range(0, 71);
        b2 = (b1 + $urandom_range(1, 71)) % 72;
        m = 72'd1 << b1;
        if ($urandom_range(0, 1) == 1) m = m | (72'd1 << b2);
        if (fmask[a] == 0) inject(a, m);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
